// File: rtl/three_level_bist_pkg.sv
// Shared types and constants for the three-level logic BIST block.
// Holds the FSM state encoding, the count width and the per-width LFSR tap masks.
package three_level_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int COUNT_W = 16;

  // Maximal-length Fibonacci taps; mask bit t-1 set for polynomial tap t.
  function automatic logic [15:0] tap_mask(input int w);
    logic [15:0] m;
    case (w)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h000C;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/three_level_bist_lfsr_step.sv
// One combinational step of a Fibonacci shift-left LFSR, feedback into bit 0.
// Shared by the pattern generator and the signature register.
module lfsr_step #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   MASK  = '0
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {cur[WIDTH-2:0], ^(cur & MASK)};

endmodule

// File: rtl/three_level_bist.sv
// LFSR-driven BIST of a three-level AND/OR circuit with MISR compaction.
// Build option: THREE_LEVEL_BIST_NOR_TERM_EN adds an XOR'd NOR term to the circuit under test.
module three_level_bist
  import three_level_bist_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_PATTERNS = 255,
  parameter int SEED         = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   golden,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   pattern,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] count
);

  localparam logic [15:0]        MASK_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0]   MASK      = MASK_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   SEED_T    = WIDTH'(SEED);
  localparam logic [WIDTH-1:0]   SEED_V    = (SEED_T == '0) ? WIDTH'(1) : SEED_T;
  localparam logic [COUNT_W-1:0] NUM_P     = COUNT_W'(NUM_PATTERNS);

  // pb[k] = p[k+1], pc[k] = p[k+2], both modulo WIDTH.
  function automatic logic [WIDTH-1:0] cut_f(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] pb, pc, s1, s3;
    pb = {p[0], p[WIDTH-1:1]};
    pc = {p[1:0], p[WIDTH-1:2]};
    s1 = p & pb;
    s3 = s1 | pc;
`ifdef THREE_LEVEL_BIST_NOR_TERM_EN
    return (s1 | s3) ^ ~(p | pc);
`else
    return s1 | s3;
`endif
  endfunction

  state_t           state_q, state_d;
  logic             armed_q;
  logic             load, step;
  logic [WIDTH-1:0] lfsr_nxt, misr_nxt;

  lfsr_step #(.WIDTH(WIDTH), .MASK(MASK)) u_lfsr (
    .cur (pattern),
    .nxt (lfsr_nxt)
  );

  lfsr_step #(.WIDTH(WIDTH), .MASK(MASK)) u_misr (
    .cur (signature),
    .nxt (misr_nxt)
  );

  // armed_q guarantees one full IDLE cycle after reset release before start is honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count + 16'd1 == NUM_P) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern   <= '0;
      signature <= '0;
      count     <= '0;
    end else if (load) begin
      pattern   <= SEED_V;
      signature <= '0;
      count     <= '0;
    end else if (step) begin
      pattern   <= lfsr_nxt;
      signature <= misr_nxt ^ cut_f(pattern);
      count     <= count + 16'd1;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = done && (signature == golden);

endmodule
